// File: rtl/guess_pkg.sv
// Shared types and constants for the number guessing game.
package guess_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_WIN  = 2'd2,
        S_LOSE = 2'd3
    } state_t;

    // Outcome of the most recent wrong guess in the current round.
    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_HI   = 2'd1,
        RES_LO   = 2'd2
    } result_t;

    localparam int MAX_TRIES_DEF = 8;

    // Active-low seven-segment patterns, bit order gfedcba.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_F     = 7'b0001110;

endpackage

// File: rtl/hex_decoder.sv
// 4-bit value to active-low seven-segment pattern (gfedcba).
module hex_decoder (
    input  logic [3:0] value,
    output logic [6:0] seg
);

    // Pure lookup from nibble to segment pattern.
    always_comb begin
        seg = 7'b1111111;
        case (value)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/guess_game.sv
// Number guessing game: key synchronisers, round FSM and registered
// seven-segment display drivers.
module guess_game
    import guess_pkg::*;
#(
    parameter int MAX_TRIES   = MAX_TRIES_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] randnum,
    input  logic       start_key,
    input  logic       submit_key,
    input  logic [7:0] guess,
    output logic       s_p,
    output logic [3:0] attempts,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam logic [3:0] TRIES_MAX = 4'(MAX_TRIES);

    logic [SYNC_STAGES-1:0] fill;
    logic [SYNC_STAGES-1:0] start_sync, submit_sync;
    logic                   start_prev, submit_prev;
    logic                   start_arm, submit_arm;
    logic                   start_evt, submit_evt;
    logic                   chain_valid;

    state_t     state, state_n;
    result_t    result, result_n;
    logic [7:0] target, target_n;
    logic [3:0] attempts_n;

    logic [6:0] seg_ghi, seg_glo, seg_thi, seg_tlo, seg_att;

    assign chain_valid = fill[SYNC_STAGES-1];

    // Marks when the synchronisers hold real key samples rather than reset zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fill <= '0;
        else     fill <= SYNC_STAGES'({fill, 1'b1});
    end

    // Start key: synchronise, then a registered rising-edge event; the arm flop
    // suppresses a key that was already held when reset released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_sync <= '0;
            start_prev <= 1'b0;
            start_arm  <= 1'b0;
            start_evt  <= 1'b0;
        end else begin
            start_sync <= SYNC_STAGES'({start_sync, start_key});
            start_prev <= start_sync[SYNC_STAGES-1];
            if (chain_valid && !start_sync[SYNC_STAGES-1]) start_arm <= 1'b1;
            start_evt  <= start_sync[SYNC_STAGES-1] & ~start_prev & start_arm;
        end
    end

    // Submit key: same synchroniser and edge detector as the start key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            submit_sync <= '0;
            submit_prev <= 1'b0;
            submit_arm  <= 1'b0;
            submit_evt  <= 1'b0;
        end else begin
            submit_sync <= SYNC_STAGES'({submit_sync, submit_key});
            submit_prev <= submit_sync[SYNC_STAGES-1];
            if (chain_valid && !submit_sync[SYNC_STAGES-1]) submit_arm <= 1'b1;
            submit_evt  <= submit_sync[SYNC_STAGES-1] & ~submit_prev & submit_arm;
        end
    end

    // Round state and game registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            attempts <= 4'd0;
            target   <= 8'd0;
            result   <= RES_NONE;
        end else begin
            state    <= state_n;
            attempts <= attempts_n;
            target   <= target_n;
            result   <= result_n;
        end
    end

    // Next-state logic; start always wins over a simultaneous submit.
    always_comb begin
        state_n    = state;
        attempts_n = attempts;
        target_n   = target;
        result_n   = result;
        case (state)
            S_IDLE: begin
                if (start_evt) begin
                    target_n   = randnum;
                    attempts_n = 4'd0;
                    result_n   = RES_NONE;
                    state_n    = S_PLAY;
                end
            end
            S_PLAY: begin
                if (start_evt) begin
                    state_n = S_IDLE;
                end else if (submit_evt && (attempts < TRIES_MAX)) begin
                    attempts_n = attempts + 4'd1;
                    if (guess == target)              state_n  = S_WIN;
                    else if (attempts_n == TRIES_MAX) state_n  = S_LOSE;
                    else if (guess > target)          result_n = RES_HI;
                    else                              result_n = RES_LO;
                end
            end
            S_WIN, S_LOSE: begin
                if (start_evt) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign s_p = (state == S_IDLE);

    hex_decoder u_dec_ghi (.value(guess[7:4]),  .seg(seg_ghi));
    hex_decoder u_dec_glo (.value(guess[3:0]),  .seg(seg_glo));
    hex_decoder u_dec_thi (.value(target[7:4]), .seg(seg_thi));
    hex_decoder u_dec_tlo (.value(target[3:0]), .seg(seg_tlo));
    hex_decoder u_dec_att (.value(attempts),    .seg(seg_att));

    // Display registers, one cycle behind the state they show.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            HEX0 <= SEG_BLANK;
            HEX1 <= SEG_BLANK;
            HEX2 <= SEG_BLANK;
            HEX3 <= SEG_BLANK;
            HEX4 <= SEG_BLANK;
            HEX5 <= SEG_BLANK;
        end else begin
            HEX0 <= seg_glo;
            HEX1 <= seg_ghi;
            HEX2 <= (state == S_WIN || state == S_LOSE) ? seg_tlo : SEG_BLANK;
            HEX3 <= (state == S_WIN || state == S_LOSE) ? seg_thi : SEG_BLANK;
            HEX4 <= (state == S_IDLE) ? SEG_BLANK : seg_att;
            case (state)
                S_PLAY:  HEX5 <= (result == RES_HI) ? SEG_H :
                                 (result == RES_LO) ? SEG_L : SEG_DASH;
                S_WIN:   HEX5 <= SEG_P;
                S_LOSE:  HEX5 <= SEG_F;
                default: HEX5 <= SEG_BLANK;
            endcase
        end
    end

endmodule

// File: tb/tb_guess_game.sv
// Directed bench for guess_game: a table of key presses with expected
// display/attempt values, plus hand-written timing and reset sequences.
module tb_guess_game;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] randnum;
    logic       start_key;
    logic       submit_key;
    logic [7:0] guess;
    logic       s_p;
    logic [3:0] attempts;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [6:0] B  = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;
    localparam logic [6:0] SH = 7'b0001001;
    localparam logic [6:0] SL = 7'b1000111;
    localparam logic [6:0] SP = 7'b0001100;
    localparam logic [6:0] SF = 7'b0001110;

    typedef struct {
        logic       st;
        logic       sb;
        logic [7:0] g;
        logic [7:0] rn;
        logic       sp;
        logic [3:0] att;
        logic [6:0] h5;
        logic [6:0] h4;
        logic [6:0] h3;
        logic [6:0] h2;
    } vec_t;

    vec_t vecs[$];

    guess_game dut (
        .clk        (clk),
        .rst        (rst),
        .randnum    (randnum),
        .start_key  (start_key),
        .submit_key (submit_key),
        .guess      (guess),
        .s_p        (s_p),
        .attempts   (attempts),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dig(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance n rising edges, then sit 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        start_key = 1'b1;
        tick(1);
        start_key = 1'b0;
        tick(7);
    endtask

    task automatic press_submit(input logic [7:0] g);
        guess = g;
        submit_key = 1'b1;
        tick(1);
        submit_key = 1'b0;
        tick(7);
    endtask

    task automatic chk_all_blank(input string nm);
        chk({nm, " HEX0"}, HEX0, B);
        chk({nm, " HEX1"}, HEX1, B);
        chk({nm, " HEX2"}, HEX2, B);
        chk({nm, " HEX3"}, HEX3, B);
        chk({nm, " HEX4"}, HEX4, B);
        chk({nm, " HEX5"}, HEX5, B);
    endtask

    initial begin
        rst        = 1'b1;
        randnum    = 8'h5A;
        start_key  = 1'b0;
        submit_key = 1'b0;
        guess      = 8'h00;

        //             st  sb  g      rn     sp  att   h5  h4        h3        h2
        vecs.push_back('{1, 0, 8'h00, 8'h5A, 0, 4'd0, DS, dig(4'h0), B,        B       });
        vecs.push_back('{0, 1, 8'h10, 8'h5A, 0, 4'd1, SL, dig(4'h1), B,        B       });
        vecs.push_back('{0, 1, 8'hF0, 8'h5A, 0, 4'd2, SH, dig(4'h2), B,        B       });
        vecs.push_back('{0, 1, 8'h5A, 8'h5A, 0, 4'd3, SP, dig(4'h3), dig(4'h5), dig(4'hA)});
        vecs.push_back('{0, 1, 8'h5A, 8'h5A, 0, 4'd3, SP, dig(4'h3), dig(4'h5), dig(4'hA)});
        vecs.push_back('{1, 0, 8'h00, 8'h5A, 1, 4'd3, B,  B,         B,        B       });
        vecs.push_back('{0, 1, 8'h00, 8'h5A, 1, 4'd3, B,  B,         B,        B       });
        vecs.push_back('{1, 0, 8'h00, 8'h3C, 0, 4'd0, DS, dig(4'h0), B,        B       });
        for (int k = 1; k <= 7; k++)
            vecs.push_back('{0, 1, 8'h00, 8'h3C, 0, 4'(k), SL, dig(4'(k)), B, B});
        vecs.push_back('{0, 1, 8'h00, 8'h3C, 0, 4'd8, SF, dig(4'h8), dig(4'h3), dig(4'hC)});
        vecs.push_back('{0, 1, 8'h00, 8'h3C, 0, 4'd8, SF, dig(4'h8), dig(4'h3), dig(4'hC)});
        vecs.push_back('{1, 0, 8'h00, 8'h3C, 1, 4'd8, B,  B,         B,        B       });
        vecs.push_back('{1, 0, 8'h00, 8'h77, 0, 4'd0, DS, dig(4'h0), B,        B       });
        vecs.push_back('{0, 1, 8'hFF, 8'h77, 0, 4'd1, SH, dig(4'h1), B,        B       });
        vecs.push_back('{0, 1, 8'h00, 8'h77, 0, 4'd2, SL, dig(4'h2), B,        B       });
        vecs.push_back('{0, 1, 8'h77, 8'h77, 0, 4'd3, SP, dig(4'h3), dig(4'h7), dig(4'h7)});
        vecs.push_back('{1, 0, 8'h77, 8'h77, 1, 4'd3, B,  B,         B,        B       });
        vecs.push_back('{1, 0, 8'h00, 8'h80, 0, 4'd0, DS, dig(4'h0), B,        B       });
        vecs.push_back('{0, 1, 8'h7F, 8'h80, 0, 4'd1, SL, dig(4'h1), B,        B       });

        // Reset state, checked while reset is still asserted.
        tick(3);
        chk("reset s_p", s_p, 1'b1);
        chk("reset attempts", attempts, 4'd0);
        chk_all_blank("reset");
        rst = 1'b0;
        tick(5);

        // Table of presses.
        for (int i = 0; i < vecs.size(); i++) begin
            guess      = vecs[i].g;
            randnum    = vecs[i].rn;
            start_key  = vecs[i].st;
            submit_key = vecs[i].sb;
            tick(1);
            start_key  = 1'b0;
            submit_key = 1'b0;
            tick(7);
            chk($sformatf("v%0d s_p", i), s_p, vecs[i].sp);
            chk($sformatf("v%0d attempts", i), attempts, vecs[i].att);
            chk($sformatf("v%0d HEX5", i), HEX5, vecs[i].h5);
            chk($sformatf("v%0d HEX4", i), HEX4, vecs[i].h4);
            chk($sformatf("v%0d HEX3", i), HEX3, vecs[i].h3);
            chk($sformatf("v%0d HEX2", i), HEX2, vecs[i].h2);
            chk($sformatf("v%0d HEX1", i), HEX1, dig(vecs[i].g[7:4]));
            chk($sformatf("v%0d HEX0", i), HEX0, dig(vecs[i].g[3:0]));
        end

        // Start and submit together in PLAY: start wins, attempts held.
        guess      = 8'h00;
        start_key  = 1'b1;
        submit_key = 1'b1;
        tick(1);
        start_key  = 1'b0;
        submit_key = 1'b0;
        tick(7);
        chk("simul s_p", s_p, 1'b1);
        chk("simul attempts", attempts, 4'd1);
        chk("simul HEX5", HEX5, B);

        // Start latency: key rises before edge N, s_p falls right after edge N+3.
        randnum   = 8'h5A;
        start_key = 1'b1;
        tick(1);
        start_key = 1'b0;
        tick(1);
        chk("latency N+1 s_p", s_p, 1'b1);
        tick(1);
        chk("latency N+2 s_p", s_p, 1'b1);
        tick(1);
        chk("latency N+3 s_p", s_p, 1'b0);
        randnum = 8'h11;
        tick(4);
        chk("latency HEX5", HEX5, DS);
        chk("latency attempts", attempts, 4'd0);
        press_submit(8'h5A);
        chk("latency target HEX5", HEX5, SP);
        chk("latency target HEX3", HEX3, dig(4'h5));
        chk("latency target HEX2", HEX2, dig(4'hA));

        // Reset mid-round with start held through the release.
        press_start();
        press_start();
        chk("pre-reset s_p", s_p, 1'b0);
        start_key = 1'b1;
        tick(1);
        rst = 1'b1;
        #1;
        chk("async reset s_p", s_p, 1'b1);
        chk("async reset attempts", attempts, 4'd0);
        chk_all_blank("async reset");
        tick(3);
        rst = 1'b0;
        tick(20);
        chk("held start s_p", s_p, 1'b1);
        chk("held start HEX5", HEX5, B);
        start_key = 1'b0;
        tick(6);
        chk("released start s_p", s_p, 1'b1);
        randnum = 8'h5A;
        press_start();
        chk("re-press s_p", s_p, 1'b0);
        chk("re-press attempts", attempts, 4'd0);

        // Long holds: each must produce exactly one event.
        guess      = 8'h00;
        submit_key = 1'b1;
        tick(100);
        submit_key = 1'b0;
        tick(7);
        chk("hold submit attempts", attempts, 4'd1);
        chk("hold submit HEX5", HEX5, SL);
        start_key = 1'b1;
        tick(100);
        start_key = 1'b0;
        tick(7);
        chk("hold start s_p", s_p, 1'b1);
        chk("hold start HEX4", HEX4, B);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/guess_game.md
GUESS_GAME -- requirements
Module: guess_game

Interface
REQ-001 Parameter MAX_TRIES, default 8: guesses allowed per round (legal range 1..15).
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth on each key input.
REQ-003 clk  input  1  the single clock; every flop is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 randnum  input  8  free-running LFSR value from the random number stage.
REQ-006 start_key  input  1  level, active-high; starts, aborts or ends a round.
REQ-007 submit_key  input  1  level, active-high; submits the current guess.
REQ-008 guess  input  8  value set on the slide switches.
REQ-009 s_p  output  1  run enable to the LFSR stage; 1 means the LFSR is generating.
REQ-010 attempts  output  4  number of guesses used in the current round.
REQ-011 HEX0..HEX5  output  7 each  active-low seven-segment drivers.

Function
REQ-012 Each key SHALL pass through a SYNC_STAGES flop synchroniser followed by a rising-edge detector; one press produces exactly one single-cycle event.
REQ-013 With SYNC_STAGES=2, a key that rises before clock edge N SHALL cause its state change at edge N+3.
REQ-014 The FSM SHALL have four states: IDLE, PLAY, WIN, LOSE.
REQ-015 s_p SHALL be 1 in IDLE and 0 in all other states, so the LFSR holds its value while a round is active.
REQ-016 IDLE + start event: latch target=randnum, clear attempts, clear the last result, go to PLAY.
REQ-017 PLAY + submit event: attempts+1; if guess==target go to WIN; else if the new attempts count equals MAX_TRIES go to LOSE; else stay in PLAY and record HI (guess>target) or LO (guess<target).
REQ-018 PLAY + start event: abort the round and return to IDLE; attempts and target are held until the next round starts.
REQ-019 Start and submit events in the same cycle SHALL be resolved with start taking priority; the submit is discarded and attempts does not change.
REQ-020 WIN or LOSE + start event: go to IDLE. Submit events in IDLE, WIN and LOSE SHALL be ignored.
REQ-021 The comparison SHALL be unsigned 8-bit. attempts SHALL never exceed MAX_TRIES and never wrap.
REQ-022 HEX outputs SHALL be registered and reflect the state and registers of the previous cycle.
REQ-023 Hex digit encoding (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Blank SHALL be 1111111.
REQ-024 HEX1:HEX0 SHALL always show guess[7:4]:guess[3:0].
REQ-025 HEX3:HEX2 SHALL show the target in WIN and LOSE only, and be blank otherwise.
REQ-026 HEX4 SHALL show attempts as a hex digit in PLAY, WIN and LOSE, and be blank in IDLE.
REQ-027 HEX5 status:
- blank in IDLE;
- '-' (0111111) in PLAY before the first miss;
- 'H' (0001001) or 'L' (1000111) after a miss;
- 'P' (0001100) in WIN;
- 'F' (0001110) in LOSE.

Reset
REQ-028 rst asserted SHALL immediately force: state=IDLE, s_p=1, attempts=0, target=0, result cleared, synchroniser and edge flops=0, all HEX outputs=1111111.
REQ-029 A key that is held high through the release of rst SHALL NOT generate an event.
REQ-030 Reset asserted mid-round SHALL abandon the round with no residual state.

Structure
REQ-031 Package guess_pkg SHALL hold the state encoding, the segment constants (blank, '-', H, L, P, F) and the default MAX_TRIES.
REQ-032 One sub-module, hex_decoder (4-bit value to 7-bit active-low segments), SHALL be instantiated for each numeric digit.
REQ-033 The synchroniser and edge detector SHALL be implemented inline, once per key.

Verification
REQ-034 Reset, hold randnum=8'h5A, pulse start_key -> s_p falls to 0 three cycles later; target=8'h5A; HEX5='-'.
REQ-035 Target 5A, guesses 8'h10, 8'hF0, 8'h5A -> HEX5 shows L, then H, then P; attempts=3; HEX3:HEX2 show 5,A.
REQ-036 MAX_TRIES=8, eight wrong guesses -> LOSE after the 8th; attempts=8; HEX5='F'; a 9th submit leaves attempts=8.
REQ-037 Start and submit raised in the same cycle during PLAY -> state returns to IDLE; s_p=1; attempts unchanged.
REQ-038 rst pulsed while in PLAY with start_key held high -> after release, state=IDLE with all HEX blank; no event until start_key falls and rises again.
REQ-039 One key held high for 100 cycles -> exactly one event is generated.
